// File: rtl/adc_rx_pkg.sv
// rtl/adc_rx_pkg.sv - shared types and helpers for the ADC frame receiver
package adc_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_e;

  // Tag fields sized for the widest legal configuration (8 status bits, 8 channels)
  typedef struct packed {
    logic [7:0] status;
    logic [2:0] ch;
    logic       last;
  } rx_tag_t;

  function automatic int frame_bits(input int n_ch, input int data_w, input int status_w);
    return n_ch * (data_w + status_w);
  endfunction

endpackage

// File: rtl/adc_frame_rx_sync_fifo.sv
// rtl/adc_frame_rx_sync_fifo.sv - first-word-fall-through FIFO with count-based full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en & ~empty;
  // A read in the same cycle frees the slot, so a full FIFO still accepts the write
  assign do_wr = wr_en & (~full | do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/adc_frame_rx.sv
// rtl/adc_frame_rx.sv - oversampling frame-sync ADC receiver, one stream word per channel
module adc_frame_rx
  import adc_rx_pkg::*;
#(
  parameter int N_CH       = 1,
  parameter int DATA_W     = 24,
  parameter int STATUS_W   = 0,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int SW  = (STATUS_W > 0) ? STATUS_W : 1,
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr_err,
  input  logic             sck,
  input  logic             fsync,
  input  logic             din,
  output logic             adc_start,
  output logic             adc_pd_n,
  output logic [OUT_W-1:0] m_data,
  output logic [SW-1:0]    m_status,
  output logic [CHW-1:0]   m_ch,
  output logic             m_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             err_short,
  output logic             err_overflow
);

  localparam int SLOT_W  = DATA_W + STATUS_W;
  localparam int FRAME_W = frame_bits(N_CH, DATA_W, STATUS_W);
  localparam int PART_W  = FRAME_W - 1;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int TAG_W   = $bits(rx_tag_t);
  localparam int FIFO_W  = OUT_W + TAG_W;

  logic [2:0] sck_s, fsync_s;
  logic [1:0] din_s;
  logic       sck_rise, fsync_rise, din_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_s   <= '0;
      fsync_s <= '0;
      din_s   <= '0;
    end else begin
      sck_s   <= {sck_s[1:0], sck};
      fsync_s <= {fsync_s[1:0], fsync};
      din_s   <= {din_s[0], din};
    end
  end

  assign sck_rise   = sck_s[1] & ~sck_s[2];
  assign fsync_rise = fsync_s[1] & ~fsync_s[2];
  assign din_bit    = din_s[1];

  rx_state_e         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [PART_W-1:0] shift_reg;
  logic              frame_done, short_err;

  assign short_err  = en & (state == SHIFT) & fsync_rise & (bit_cnt < CNT_W'(FRAME_W));
  assign frame_done = en & (state == SHIFT) & ~fsync_rise & sck_rise &
                      (bit_cnt == CNT_W'(FRAME_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (!en) begin
      state <= IDLE;
    end else if (fsync_rise) begin
      state     <= SHIFT;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (state == SHIFT && sck_rise) begin
      shift_reg <= {shift_reg[PART_W-2:0], din_bit};
      bit_cnt   <= bit_cnt + 1'b1;
      if (frame_done) state <= DONE;
    end
  end

  logic [FRAME_W-1:0] frame_reg;
  logic               emit_busy;
  logic [CHW-1:0]     emit_ch;
  logic [SLOT_W-1:0]  slot;
  logic [SW-1:0]      status_val;
  logic [OUT_W-1:0]   data_ext;
  rx_tag_t            tag;
  logic               wr_en;
  logic [FIFO_W-1:0]  wr_data;

  // Channel 0 arrived first, so it sits in the most significant slot
  always_comb begin
    slot     = SLOT_W'(frame_reg >> (SLOT_W * (N_CH - 1 - int'(emit_ch))));
    data_ext = OUT_W'($signed(slot[SLOT_W-1 -: DATA_W]));
    tag        = '0;
    tag.status = 8'(status_val);
    tag.ch     = 3'(emit_ch);
    tag.last   = (emit_ch == CHW'(N_CH - 1));
  end

  if (STATUS_W > 0) begin : g_status
    assign status_val = slot[SW-1:0];
  end else begin : g_no_status
    assign status_val = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_reg <= '0;
      emit_busy <= 1'b0;
      emit_ch   <= '0;
      wr_en     <= 1'b0;
      wr_data   <= '0;
    end else begin
      wr_en   <= emit_busy;
      wr_data <= {data_ext, tag};
      if (frame_done && !emit_busy) begin
        frame_reg <= {shift_reg, din_bit};
        emit_busy <= 1'b1;
        emit_ch   <= '0;
      end else if (emit_busy) begin
        if (emit_ch == CHW'(N_CH - 1)) emit_busy <= 1'b0;
        emit_ch <= emit_ch + 1'b1;
      end
    end
  end

  logic              fifo_full, fifo_empty;
  logic [FIFO_W-1:0] rd_data;
  rx_tag_t           rd_tag;
  logic              unused_tag_bits;
  logic              overflow_now;

  sync_fifo #(.WIDTH(FIFO_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (fifo_full),
    .rd_en   (m_ready),
    .rd_data (rd_data),
    .empty   (fifo_empty)
  );

  assign rd_tag          = rx_tag_t'(rd_data[TAG_W-1:0]);
  assign unused_tag_bits = ^rd_tag;
  assign m_valid  = ~fifo_empty;
  assign m_data   = rd_data[FIFO_W-1 -: OUT_W];
  assign m_status = rd_tag.status[SW-1:0];
  assign m_ch     = rd_tag.ch[CHW-1:0];
  assign m_last   = rd_tag.last;

  assign overflow_now = (frame_done & emit_busy) | (wr_en & fifo_full & ~(m_valid & m_ready));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
      adc_start    <= 1'b0;
      adc_pd_n     <= 1'b1;
    end else begin
      err_short    <= (err_short & ~clr_err) | short_err;
      err_overflow <= (err_overflow & ~clr_err) | overflow_now;
      adc_start    <= en;
      adc_pd_n     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_frame_rx.sv
// tb/tb_adc_frame_rx.sv - scoreboard bench for adc_frame_rx, single- and four-channel instances
module tb_adc_frame_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, clr_err;
  logic sck1, fs1, din1, ready1;
  logic sck4, fs4, din4, ready4;

  logic        start1, pd1, valid1, last1, es1, eo1;
  logic [31:0] data1;
  logic [0:0]  st1, ch1;
  logic        start4, pd4, valid4, last4, es4, eo4;
  logic [31:0] data4;
  logic [7:0]  st4;
  logic [1:0]  ch4;

  int total = 0;
  int bad   = 0;
  logic [43:0] q1[$];
  logic [43:0] q4[$];
  logic [23:0] ws[4];

  adc_frame_rx #(.N_CH(1), .DATA_W(24), .STATUS_W(0), .OUT_W(32), .FIFO_DEPTH(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err),
    .sck(sck1), .fsync(fs1), .din(din1),
    .adc_start(start1), .adc_pd_n(pd1),
    .m_data(data1), .m_status(st1), .m_ch(ch1), .m_last(last1),
    .m_valid(valid1), .m_ready(ready1),
    .err_short(es1), .err_overflow(eo1)
  );

  adc_frame_rx #(.N_CH(4), .DATA_W(24), .STATUS_W(8), .OUT_W(32), .FIFO_DEPTH(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr_err(clr_err),
    .sck(sck4), .fsync(fs4), .din(din4),
    .adc_start(start4), .adc_pd_n(pd4),
    .m_data(data4), .m_status(st4), .m_ch(ch4), .m_last(last4),
    .m_valid(valid4), .m_ready(ready4),
    .err_short(es4), .err_overflow(eo4)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  function automatic logic [43:0] ent(input logic [23:0] w, input logic [7:0] st,
                                      input int ch, input logic last);
    logic [31:0] d;
    d = {{8{w[23]}}, w};
    return {d, st, 3'(ch), last};
  endfunction

  function automatic logic [127:0] frame4(input logic [23:0] w0, input logic [23:0] w1,
                                          input logic [23:0] w2, input logic [23:0] w3,
                                          input logic [7:0] st);
    return {w0, st, w1, st, w2, st, w3, st};
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid1 && ready1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL m1_extra: got word %0h want none", data1);
      end else check("m1_word", {data1, 8'(st1), 3'(ch1), last1}, q1.pop_front());
    end
    if (rst_n && valid4 && ready4) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL m4_extra: got word %0h want none", data4);
      end else check("m4_word", {data4, st4, 3'(ch4), last4}, q4.pop_front());
    end
  end

  task automatic send_bit(input int w, input logic b);
    @(negedge clk);
    if (w == 1) begin sck1 = 1'b0; din1 = b; end
    else        begin sck4 = 1'b0; din4 = b; end
    repeat (2) @(negedge clk);
    if (w == 1) sck1 = 1'b1; else sck4 = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic fsync_pulse(input int w);
    @(negedge clk);
    if (w == 1) fs1 = 1'b1; else fs4 = 1'b1;
    repeat (2) @(negedge clk);
    if (w == 1) fs1 = 1'b0; else fs4 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_bits(input int w, input logic [127:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w, f[i]);
  endtask

  task automatic send_frame(input int w, input logic [127:0] f, input int n);
    fsync_pulse(w);
    send_bits(w, f, n);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300 && (q1.size() != 0 || q4.size() != 0); n++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr_err = 1'b0;
    sck1 = 0; fs1 = 0; din1 = 0; ready1 = 1;
    sck4 = 0; fs4 = 0; din4 = 0; ready4 = 1;
    repeat (3) @(negedge clk);
    check("rst_valid1", valid1, 0);
    check("rst_data1", data1, 0);
    check("rst_valid4", valid4, 0);
    check("rst_status4", st4, 0);
    check("rst_errs", {es1, eo1, es4, eo4}, 0);
    check("rst_pins", {start1, pd1, start4, pd4}, 4'b0101);
    rst_n = 1'b1; en = 1'b1;
    repeat (2) @(negedge clk);
    check("adc_start", {start1, start4}, 2'b11);

    // single channel, most negative-ish code, and exact output latency
    q1.push_back(ent(24'h800001, 8'h00, 0, 1'b1));
    send_frame(1, 128'h800001, 24);
    repeat (2) @(negedge clk);
    check("lat_e2", valid1, 0);
    @(negedge clk);
    check("lat_e3", valid1, 1);
    q1.push_back(ent(24'h7FFFFF, 8'h00, 0, 1'b1));
    send_frame(1, 128'h7FFFFF, 24);
    wait_drain();

    // short frame: 17 of 24 bits, then a full frame
    check("short_pre", es1, 0);
    fsync_pulse(1);
    send_bits(1, 128'h1FFFF, 17);
    q1.push_back(ent(24'h123456, 8'h00, 0, 1'b1));
    send_frame(1, 128'h123456, 24);
    wait_drain();
    check("short_flag", es1, 1);
    pulse_clr();
    check("short_clr", es1, 0);

    // enable dropped mid-frame
    fsync_pulse(1);
    send_bits(1, 128'h3FF, 10);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
    q1.push_back(ent(24'hABCDEF, 8'h00, 0, 1'b1));
    send_frame(1, 128'hABCDEF, 24);
    wait_drain();
    check("abort_errs", {es1, eo1}, 0);

    // four channels with status byte
    q4.push_back(ent(24'h000001, 8'hA5, 0, 1'b0));
    q4.push_back(ent(24'h7FFFFF, 8'hA5, 1, 1'b0));
    q4.push_back(ent(24'h800000, 8'hA5, 2, 1'b0));
    q4.push_back(ent(24'h123456, 8'hA5, 3, 1'b1));
    send_frame(4, frame4(24'h000001, 24'h7FFFFF, 24'h800000, 24'h123456, 8'hA5), 128);
    wait_drain();

    // back-pressure: five frames into a 16-entry FIFO
    ready4 = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      for (int k = 0; k < 4; k++) begin
        ws[k] = 24'(j * 256 + k);
        if (j <= 4) q4.push_back(ent(ws[k], 8'(j), k, k == 3));
      end
      send_frame(4, frame4(ws[0], ws[1], ws[2], ws[3], 8'(j)), 128);
    end
    repeat (10) @(negedge clk);
    check("ovf_flag", eo4, 1);
    check("ovf_hold_valid", valid4, 1);
    check("ovf_hold_data", {data4, st4, ch4, last4}, {32'h00000100, 8'h01, 2'd0, 1'b0});
    ready4 = 1'b1;
    wait_drain();
    check("ovf_drained", valid4, 0);
    pulse_clr();
    check("ovf_clr", eo4, 0);

    // reset while the four-channel emit is running
    ready4 = 1'b0;
    send_frame(4, frame4(24'h111111, 24'h222222, 24'h333333, 24'h444444, 8'h5A), 128);
    for (int i = 0; i < 20 && !valid4; i++) @(negedge clk);
    check("rst_emit_seen", valid4, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_emit_valid", valid4, 0);
    check("rst_emit_data", data4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_no_residual", valid4, 0);
    check("rst_no_err", {es4, eo4}, 0);
    ready4 = 1'b1;

    wait_drain();
    check("q1_empty", q1.size(), 0);
    check("q4_empty", q4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_frame_rx.md
# adc_frame_rx

Parametrised, fully clk-synchronous receiver for daisy-chained delta-sigma ADC serial frames (frame-sync mode: SCLK, FSYNC and DOUT all driven by the converter). It oversamples the serial lines, deserialises N_CH channel words per frame and sign-extends each one. Each word is delivered on a valid/ready stream through an internal FIFO, with frame-error and overflow detection. It sits between the ADC pins and the DAQ packetiser and replaces the single-channel, sck-clocked capture path.

## Interface
- N_CH, 1: channels per frame (daisy-chain length), 1..8
- DATA_W, 24: conversion bits per channel, MSB first
- STATUS_W, 0: status bits following each conversion word; 0 or 8
- OUT_W, 32: output sample width, ≥ DATA_W, sign-extended
- FIFO_DEPTH, 16: output FIFO entries, power of 2, ≥ 2·N_CH
- clk  in  1  system clock; ≥ 4× sck frequency
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  receive enable
- clr_err  in  1  one-cycle pulse, clears sticky error flags
- sck, fsync, din  in  1 each  asynchronous ADC serial pins
- adc_start  out  1  ADC START pin, registered copy of en
- adc_pd_n  out  1  ADC power-down pin, 1 out of reset
- m_data  out  OUT_W  sign-extended sample
- m_status  out  max(STATUS_W,1)  status bits; 0 when STATUS_W=0
- m_ch  out  max($clog2(N_CH),1)  channel index, 0 = first in frame
- m_last  out  1  word is channel N_CH-1
- m_valid  out  1  word available
- m_ready  in  1  consumer accept; transfer when m_valid & m_ready
- err_short  out  1  sticky, frame ended early
- err_overflow  out  1  sticky, word dropped due to full FIFO

## Operation
- sck, fsync, din each pass through a 2-FF synchroniser plus a third register for edge detection. din is taken from the same stage as sck, so each bit is aligned to its sck edge.
- FRAME_BITS = N_CH·(DATA_W+STATUS_W); bit counter width $clog2(FRAME_BITS+1).
- FSM states:
  - IDLE: entered from reset or when en=0. A synchronised fsync rising edge with en=1 clears the shift register and bit counter and goes to SHIFT.
  - SHIFT: each sck rising edge shifts din into the LSB and increments the count. When count reaches FRAME_BITS, shift_reg is copied to frame_reg, emit is started, and the FSM goes to DONE.
  - DONE: further sck edges are ignored. An fsync rising edge goes to SHIFT (new frame).
- fsync rising edge while in SHIFT with count < FRAME_BITS: set err_short, discard the partial frame, restart SHIFT with the count at 0.
- Emit: a counter walks channels 0..N_CH-1, writing one FIFO entry per clk. Channel 0 is the first-received word.
  - Data is {sign-extended DATA_W bits, status, ch, last}.
- If a frame completes while the previous emit is still running, the new frame is dropped and err_overflow is set. This cannot happen at legal clock ratios.
- A FIFO write while the FIFO is full drops that word and sets err_overflow. Remaining channels of the frame are still attempted.
- Sticky flags are cleared only by clr_err or reset. If a new error and clr_err occur in the same cycle, the flag ends set.
- en falling aborts any frame in progress (no error flag, no write) and forces IDLE. The FIFO keeps draining.
- Reset mid-frame or mid-emit: FSM to IDLE, FIFO emptied, partial data lost.
- Reset values:
  - m_valid=0, m_data=0, m_status=0, m_ch=0, m_last=0
  - err_short=0, err_overflow=0
  - adc_start=0, adc_pd_n=1

## Timing
- Pin sck rising edge → edge detected at cycle E, which is pin edge + 3 clk worst case.
- Last bit detected at E → frame_reg loaded at E+1 → channel k written at E+2+k.
- First-word-fall-through FIFO: m_valid rises 1 cycle after the write to an empty FIFO, so channel 0 is presented at E+3.
- m_data, m_status, m_ch and m_last hold while m_valid & !m_ready.
- A simultaneous FIFO read and write when full is allowed. The write is accepted and no overflow is flagged.
- Minimum sck high/low time: 2 clk periods. Minimum fsync high time: 2 clk periods.

## Structure
- Package adc_rx_pkg holds:
  - enum rx_state_e {IDLE, SHIFT, DONE}
  - function frame_bits(n_ch, data_w, status_w)
  - packed struct for the FIFO entry type
- Sub-module sync_fifo, parametrised by width and depth:
  - first-word-fall-through
  - full/empty flags
  - count-based pointers with wrap-around

## Test plan
- N_CH=1, DATA_W=24, one frame carrying 0x800001 → m_data=0xFF800001, m_ch=0, m_last=1, m_valid at E+3.
- N_CH=4, STATUS_W=8, frame of words 0x000001/0x7FFFFF/0x800000/0x123456 with status 0xA5 → four beats, ch 0..3, m_last only on ch 3, m_status=0xA5 each.
- fsync re-asserted after 17 of 24 bits → err_short=1, no FIFO write, following full frame received correctly.
- m_ready=0, FIFO_DEPTH=16, N_CH=4, 5 frames → 16 words held, err_overflow=1, drained words are frames 1-4 in order.
- en dropped mid-frame, then raised, then new frame → no output for the aborted frame, no error flag, new frame correct.
- rst_n low during emit of a 4-channel frame → m_valid=0 next cycle, no residual words after reset release.
